// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared types and helpers for the 68010 local-bus arbitration responder.
package cpu_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant   = 2'd1,
    StOwned   = 2'd2,
    StRelease = 2'd3
  } state_e;

  // Width of the grant-age counter; it must hold GRANT_TIMEOUT-1.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// BR/BG/BGACK handshake plus CPU-side strobes and driver controls.
interface cpu_bus_arbiter_if;
  logic BR_n;
  logic BGACK_n;
  logic CPU_AS_n;
  logic CPU_RMW;
  logic BG_n;
  logic CPU_HOLD;
  logic BUS_RELEASE;
  logic TIMEOUT;

  // Arbiter side.
  modport slave (
    input  BR_n, BGACK_n, CPU_AS_n, CPU_RMW,
    output BG_n, CPU_HOLD, BUS_RELEASE, TIMEOUT
  );

  // DVMA controller / CPU side.
  modport master (
    output BR_n, BGACK_n, CPU_AS_n, CPU_RMW,
    input  BG_n, CPU_HOLD, BUS_RELEASE, TIMEOUT
  );
endinterface

// File: rtl/cpu_bus_arbiter_bus_sync.sv
// Multi-flop synchronizer for an asynchronous active-low bus line; resets negated.
module bus_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [Stages-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '1;
    end else begin
      chain_q <= {chain_q[Stages-2:0], d};
    end
  end

  assign q = chain_q[Stages-1];

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Grant end of the DVMA BR/BG/BGACK handshake: grants the local bus outside
// indivisible CPU cycles and withdraws a grant that is never acknowledged.
module cpu_bus_arbiter
  import cpu_bus_arbiter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned GRANT_TIMEOUT = 64
) (
  input  logic CLK,
  input  logic RESET,
  cpu_bus_arbiter_if.slave bus
);

  localparam int unsigned CntW = cnt_width(GRANT_TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(GRANT_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic            br_n_sync, bgack_n_sync;
  logic            br_s, bgack_s;

  bus_sync #(
    .Stages (SYNC_STAGES)
  ) u_br_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (bus.BR_n),
    .q   (br_n_sync)
  );

  bus_sync #(
    .Stages (SYNC_STAGES)
  ) u_bgack_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (bus.BGACK_n),
    .q   (bgack_n_sync)
  );

  assign br_s    = ~br_n_sync;
  assign bgack_s = ~bgack_n_sync;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // An acknowledge wins so a master already holding the bus is recognised.
        if (bgack_s) begin
          state_d = StOwned;
        end else if (br_s && !bus.CPU_RMW) begin
          state_d = StGrant;
        end
      end
      StGrant: begin
        cnt_d = cnt_q + 1'b1;
        if (bgack_s) begin
          state_d = StOwned;
          cnt_d   = '0;
        end else if (!br_s) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d   = StIdle;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end
      end
      StOwned: begin
        if (!bgack_s) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        state_d = bgack_s ? StOwned : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.BG_n        = (state_q != StGrant);
  assign bus.BUS_RELEASE = (state_q == StOwned) || (state_q == StRelease);
  // While granted the CPU may finish its current cycle but not start another.
  assign bus.CPU_HOLD    = bus.BUS_RELEASE || ((state_q == StGrant) && bus.CPU_AS_n);
  assign bus.TIMEOUT     = timeout_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed-vector bench for cpu_bus_arbiter (SYNC_STAGES=2, GRANT_TIMEOUT=8).
module tb_cpu_bus_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  cpu_bus_arbiter_if bus ();

  cpu_bus_arbiter #(
    .SYNC_STAGES   (2),
    .GRANT_TIMEOUT (8)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic bg, input logic hold,
                         input logic rel, input logic to);
    chk({tag, ".bg_n"}, bus.BG_n, bg);
    chk({tag, ".hold"}, bus.CPU_HOLD, hold);
    chk({tag, ".rel"}, bus.BUS_RELEASE, rel);
    chk({tag, ".timeout"}, bus.TIMEOUT, to);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.BR_n = 1'b1;
    bus.BGACK_n = 1'b1;
    bus.CPU_AS_n = 1'b1;
    bus.CPU_RMW = 1'b0;
    tick();
    tick();
    chk_out("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("idle", 1'b1, 1'b0, 1'b0, 1'b0);

    // Basic handshake
    bus.BR_n = 1'b0;
    tick();
    tick();
    chk("hs.bg_before", bus.BG_n, 1'b1);
    tick();
    chk_out("hs.grant", 1'b0, 1'b1, 1'b0, 1'b0);
    bus.BGACK_n = 1'b0;
    tick();
    chk("hs.rel_k0", bus.BUS_RELEASE, 1'b0);
    bus.BR_n = 1'b1;
    tick();
    chk("hs.rel_k1", bus.BUS_RELEASE, 1'b0);
    chk("hs.bg_k1", bus.BG_n, 1'b0);
    tick();
    chk_out("hs.owned", 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hs.owned_hold", bus.BUS_RELEASE, 1'b1);
    end
    bus.BGACK_n = 1'b1;
    tick();
    chk("hs.rel_j0", bus.BUS_RELEASE, 1'b1);
    tick();
    chk("hs.rel_j1", bus.BUS_RELEASE, 1'b1);
    tick();
    chk_out("hs.release", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("hs.idle", 1'b1, 1'b0, 1'b0, 1'b0);

    // Mid-cycle request
    bus.CPU_AS_n = 1'b0;
    bus.BR_n = 1'b0;
    tick();
    tick();
    chk("mid.bg_before", bus.BG_n, 1'b1);
    tick();
    chk_out("mid.grant_as", 1'b0, 1'b0, 1'b0, 1'b0);
    bus.CPU_AS_n = 1'b1;
    #1;
    chk("mid.hold_as_hi", bus.CPU_HOLD, 1'b1);
    bus.BR_n = 1'b1;
    tick();
    tick();
    chk("mid.bg_drop_pending", bus.BG_n, 1'b0);
    tick();
    chk_out("mid.withdrawn", 1'b1, 1'b0, 1'b0, 1'b0);

    // RMW lockout
    bus.CPU_RMW = 1'b1;
    bus.BR_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rmw.blocked", bus.BG_n, 1'b1);
    end
    bus.CPU_RMW = 1'b0;
    tick();
    chk("rmw.granted", bus.BG_n, 1'b0);
    bus.CPU_RMW = 1'b1;
    tick();
    chk("rmw.no_revoke", bus.BG_n, 1'b0);
    bus.CPU_RMW = 1'b0;
    bus.BR_n = 1'b1;
    tick();
    tick();
    tick();
    chk_out("rmw.idle", 1'b1, 1'b0, 1'b0, 1'b0);

    // Timeout: BG_n low for exactly 8 cycles, pulse, one idle cycle, re-grant
    bus.BR_n = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("to.bg_low", bus.BG_n, 1'b0);
      chk("to.no_pulse", bus.TIMEOUT, 1'b0);
    end
    tick();
    chk_out("to.pulse", 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("to.regrant", 1'b0, 1'b1, 1'b0, 1'b0);

    // Simultaneous BR drop and BGACK: acknowledge wins
    bus.BR_n = 1'b1;
    bus.BGACK_n = 1'b0;
    tick();
    tick();
    chk("sim.still_grant", bus.BG_n, 1'b0);
    tick();
    chk_out("sim.owned", 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    chk("sim.no_pulse", bus.TIMEOUT, 1'b0);

    // Reset mid-ownership with BGACK held
    rst = 1'b1;
    tick();
    chk_out("rst.mid", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("rst.e1", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("rst.e2", 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("rst.reowned", 1'b1, 1'b1, 1'b1, 1'b0);
    bus.BGACK_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk_out("rst.final_idle", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
- CPU-side bus arbitration responder for the 68010 local bus on the 120 cpu board; the grant end of the DVMA controller's BR/BG/BGACK handshake.
- Synchronizes bus requests and issues bus grant once no indivisible CPU cycle is in progress.
- Holds off new CPU cycles while a DVMA master owns the bus, and signals when CPU drivers must float.
- Re-arbitrates if a grant is never acknowledged.

Parameters:
- SYNC_STAGES, 2, flops in each BR_n/BGACK_n synchronizer chain (min 2).
- GRANT_TIMEOUT, 64, cycles BG may stay asserted without BGACK before the grant is withdrawn (min 2).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- BR_n  input  1  bus request from DVMA controller, async, active low.
- BGACK_n  input  1  bus grant acknowledge from DVMA controller, async, active low.
- CPU_AS_n  input  1  CPU address strobe, CLK-synchronous, active low.
- CPU_RMW  input  1  CPU is in an indivisible read-modify-write sequence (TAS).
- BG_n  output  1  bus grant, active low, registered.
- CPU_HOLD  output  1  CPU must not start a new bus cycle.
- BUS_RELEASE  output  1  CPU address/data/strobe drivers tri-stated.
- TIMEOUT  output  1  one-cycle pulse when an unacknowledged grant is withdrawn.

Behaviour:
- Interface: one clock, CLK; reset is synchronous and active-high, RESET.
- Reset values:
  - sync chains all 1 (negated); state IDLE; counter 0.
  - BG_n=1, CPU_HOLD=0, BUS_RELEASE=0, TIMEOUT=0.
  - RESET mid-ownership forces IDLE on the next edge. OWNED is re-entered only via the BGACK rule below.
- Synchronized signals: br_s = ~BR_n and bgack_s = ~BGACK_n, each after SYNC_STAGES flops. CPU_AS_n and CPU_RMW are used directly.
- States (encoding in package): IDLE, GRANT, OWNED, RELEASE.
- IDLE (CPU owns the bus):
  - bgack_s -> OWNED. This has priority and covers a master that already holds the bus after reset.
  - else br_s & ~CPU_RMW -> GRANT.
  - else stay.
- GRANT:
  - BG_n=0, decoded from the registered state.
  - CPU_HOLD=1 whenever CPU_AS_n=1; the current CPU cycle may complete and no new one starts.
  - Counter increments each cycle.
  - bgack_s -> OWNED. This wins over a simultaneous BR drop or timeout.
  - else ~br_s -> IDLE (grant withdrawn, no pulse).
  - else counter == GRANT_TIMEOUT-1 -> IDLE and pulse TIMEOUT for 1 cycle.
  - Counter clears on every GRANT exit.
- OWNED:
  - BG_n=1, CPU_HOLD=1, BUS_RELEASE=1.
  - ~bgack_s -> RELEASE.
  - br_s re-assertion while OWNED is ignored until release.
- RELEASE:
  - One turnaround cycle: BG_n=1, CPU_HOLD=1, BUS_RELEASE=1.
  - Then bgack_s -> OWNED; else IDLE.
  - A pending br_s is then granted from IDLE (minimum one IDLE cycle between owners).
- Latency (SYNC_STAGES=2, CPU_RMW=0):
  - BR_n sampled low at edge 0 -> BG_n low after edge 2.
  - BGACK_n sampled low at edge k -> BUS_RELEASE high after edge k+2.
- After a timeout with BR still asserted: one IDLE cycle, then re-grant.
- CPU_RMW=1 blocks only the IDLE->GRANT transition; it never revokes an existing grant.
- TIMEOUT is never asserted outside the GRANT->IDLE timeout transition.

Decomposition:
- Package cpu_bus_arbiter_pkg:
  - state typedef (2-bit enum: IDLE, GRANT, OWNED, RELEASE);
  - counter width function, clog2(GRANT_TIMEOUT).
- Sub-module bus_sync: parameterized SYNC_STAGES flop chain with reset value 1. Instantiated twice, for BR_n and BGACK_n.

Test Plan:
- Basic handshake:
  - Stimulus: reset, then BR_n=0 at cycle 10 with CPU idle (CPU_AS_n=1); BGACK_n=0 at cycle 15; BR_n=1 at cycle 16; BGACK_n=1 at cycle 30.
  - Response: BG_n=0 from cycle 13; BUS_RELEASE=1 from cycle 18 (BGACK_n sampled low at edge 15, +2 edges) and stays 1 through the RELEASE turnaround; IDLE with BUS_RELEASE=0 at cycle 34.
- Mid-cycle request:
  - Stimulus: BR_n=0 while CPU_AS_n=0 for 5 more cycles.
  - Response: BG_n=0 after 3 edges; CPU_HOLD=0 while CPU_AS_n=0, CPU_HOLD=1 the cycle CPU_AS_n=1.
- RMW lockout:
  - Stimulus: CPU_RMW=1 for 8 cycles overlapping BR_n=0.
  - Response: BG_n stays 1 until CPU_RMW drops, then 0 on the next edge.
- Timeout:
  - Stimulus: GRANT_TIMEOUT=8, BR_n held 0, BGACK_n never asserted.
  - Response: BG_n=0 for exactly 8 cycles, one-cycle TIMEOUT pulse, BG_n=1 for one cycle, then BG_n=0 again.
- Simultaneous events:
  - Stimulus: in GRANT, BR_n=1 and BGACK_n=0 on the same edge.
  - Response: state goes to OWNED; BUS_RELEASE=1; no TIMEOUT.
- Reset mid-ownership:
  - Stimulus: assert RESET for 1 cycle during OWNED while BGACK_n stays 0.
  - Response: all outputs at reset values, then BUS_RELEASE=1 again 3 edges after RESET drops; BG_n never goes 0.
